// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for a 5-stage RV32I pipe without forwarding.
// Shadows the E/M slots to drive stall/flush controls, PC redirect and wait supervision.
module pipe_hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_valid,
  input  logic [4:0]       d_rs1,
  input  logic             d_rs1_used,
  input  logic [4:0]       d_rs2,
  input  logic             d_rs2_used,
  input  logic [4:0]       d_rd,
  input  logic             d_rd_we,
  input  logic             d_is_branch,
  input  logic             d_is_jump,
  input  logic             d_is_mem,
  input  logic             e_cond,
  input  logic             m_mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             stall_WB,
  output logic             flush_F,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_M,
  output logic             flush_WB,
  output logic             pc_redirect,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned WAIT_W = 16;

  logic             e_v_q, e_we_q, e_br_q, e_jmp_q, e_mem_q;
  logic             e_v_d, e_we_d, e_br_d, e_jmp_d, e_mem_d;
  logic [4:0]       e_rd_q, e_rd_d;
  logic             m_v_q, m_we_q, m_taken_q, m_mem_q;
  logic             m_v_d, m_we_d, m_taken_d, m_mem_d;
  logic [4:0]       m_rd_q, m_rd_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic memwait, redir, raw, rs1_hit, rs2_hit, e_taken;

  // A WB-stage writer is deliberately absent: the regfile writes it on the falling edge.
  assign rs1_hit = d_rs1_used && (d_rs1 != 5'd0) &&
                   ((e_v_q && e_we_q && (e_rd_q == d_rs1)) ||
                    (m_v_q && m_we_q && (m_rd_q == d_rs1)));
  assign rs2_hit = d_rs2_used && (d_rs2 != 5'd0) &&
                   ((e_v_q && e_we_q && (e_rd_q == d_rs2)) ||
                    (m_v_q && m_we_q && (m_rd_q == d_rs2)));

  assign memwait = m_v_q && m_mem_q && !m_mem_ready;
  assign redir   = m_v_q && m_taken_q;
  assign raw     = d_valid && (rs1_hit || rs2_hit);
  assign e_taken = e_v_q && ((e_br_q && e_cond) || e_jmp_q);

  always_comb begin
    stall_F     = 1'b0;
    stall_D     = 1'b0;
    stall_E     = 1'b0;
    stall_M     = 1'b0;
    stall_WB    = 1'b0;
    flush_F     = 1'b0;
    flush_D     = 1'b0;
    flush_E     = 1'b0;
    flush_M     = 1'b0;
    flush_WB    = 1'b0;
    pc_redirect = 1'b0;
    if (memwait) begin
      stall_F  = 1'b1;
      stall_D  = 1'b1;
      stall_E  = 1'b1;
      stall_M  = 1'b1;
      flush_WB = 1'b1;
    end else if (redir) begin
      pc_redirect = 1'b1;
      flush_D     = 1'b1;
      flush_E     = 1'b1;
      flush_M     = 1'b1;
    end else if (raw) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
      flush_E = 1'b1;
    end
  end

  // Shadow slots mirror exactly what the datapath stage registers do this edge.
  always_comb begin
    e_v_d   = e_v_q;
    e_rd_d  = e_rd_q;
    e_we_d  = e_we_q;
    e_br_d  = e_br_q;
    e_jmp_d = e_jmp_q;
    e_mem_d = e_mem_q;
    if (!stall_E) begin
      if (flush_E) begin
        e_v_d = 1'b0;
      end else begin
        e_v_d   = d_valid;
        e_rd_d  = d_rd;
        e_we_d  = d_rd_we;
        e_br_d  = d_is_branch;
        e_jmp_d = d_is_jump;
        e_mem_d = d_is_mem;
      end
    end

    m_v_d     = m_v_q;
    m_rd_d    = m_rd_q;
    m_we_d    = m_we_q;
    m_taken_d = m_taken_q;
    m_mem_d   = m_mem_q;
    if (!stall_M) begin
      if (flush_M) begin
        m_v_d = 1'b0;
      end else begin
        m_v_d     = e_v_q;
        m_rd_d    = e_rd_q;
        m_we_d    = e_we_q;
        m_taken_d = e_taken;
        m_mem_d   = e_mem_q;
      end
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (memwait) begin
      wait_cnt_d = (wait_cnt_q != {WAIT_W{1'b1}}) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
    end
    mem_timeout_d = mem_timeout_q ||
                    (memwait && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT - 1)));
    stall_cnt_d = stall_cnt_q;
    if (stall_F && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_v_q         <= 1'b0;
      e_rd_q        <= 5'd0;
      e_we_q        <= 1'b0;
      e_br_q        <= 1'b0;
      e_jmp_q       <= 1'b0;
      e_mem_q       <= 1'b0;
      m_v_q         <= 1'b0;
      m_rd_q        <= 5'd0;
      m_we_q        <= 1'b0;
      m_taken_q     <= 1'b0;
      m_mem_q       <= 1'b0;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
    end else begin
      e_v_q         <= e_v_d;
      e_rd_q        <= e_rd_d;
      e_we_q        <= e_we_d;
      e_br_q        <= e_br_d;
      e_jmp_q       <= e_jmp_d;
      e_mem_q       <= e_mem_d;
      m_v_q         <= m_v_d;
      m_rd_q        <= m_rd_d;
      m_we_q        <= m_we_d;
      m_taken_q     <= m_taken_d;
      m_mem_q       <= m_mem_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scenario bench for pipe_hazard_ctrl: per-cycle expected controls are queued as stimulus
// is driven and popped when the combinational outputs settle mid-cycle.
module tb_pipe_hazard_ctrl;

  typedef logic [10:0] ctl_t;
  // {stall_F,stall_D,stall_E,stall_M,stall_WB,flush_F,flush_D,flush_E,flush_M,flush_WB,pc_redirect}
  localparam ctl_t NONE = 11'b00000000000;
  localparam ctl_t RAW  = 11'b11000001000;
  localparam ctl_t MW   = 11'b11110000010;
  localparam ctl_t RD   = 11'b00000011101;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       used;
    logic [4:0] rd;
    logic       we, br, jmp, mem, cond, rdy;
    ctl_t       ctl;
    logic       tmo;
    logic       tmo4;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic d_valid, d_rs1_used, d_rs2_used, d_rd_we, d_is_branch, d_is_jump, d_is_mem;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic e_cond, m_mem_ready;
  logic stall_F, stall_D, stall_E, stall_M, stall_WB;
  logic flush_F, flush_D, flush_E, flush_M, flush_WB, pc_redirect, mem_timeout;
  logic [15:0] stall_cnt;
  logic stall_F_t, stall_D_t, stall_E_t, stall_M_t, stall_WB_t;
  logic flush_F_t, flush_D_t, flush_E_t, flush_M_t, flush_WB_t, pc_redirect_t, mem_timeout_t;
  logic [2:0] stall_cnt_t;
  ctl_t ctl_obs;

  int n_cmp = 0;
  int n_err = 0;
  step_t sb[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs1_used(d_rs1_used),
    .d_rs2(d_rs2), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_rd_we(d_rd_we),
    .d_is_branch(d_is_branch), .d_is_jump(d_is_jump), .d_is_mem(d_is_mem),
    .e_cond(e_cond), .m_mem_ready(m_mem_ready),
    .stall_F(stall_F), .stall_D(stall_D), .stall_E(stall_E), .stall_M(stall_M),
    .stall_WB(stall_WB), .flush_F(flush_F), .flush_D(flush_D), .flush_E(flush_E),
    .flush_M(flush_M), .flush_WB(flush_WB), .pc_redirect(pc_redirect),
    .mem_timeout(mem_timeout), .stall_cnt(stall_cnt)
  );

  // Short timeout and a 3-bit counter expose the timeout edge and counter saturation.
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(3)) dut_to (
    .clk(clk), .reset(reset), .d_valid(d_valid), .d_rs1(d_rs1), .d_rs1_used(d_rs1_used),
    .d_rs2(d_rs2), .d_rs2_used(d_rs2_used), .d_rd(d_rd), .d_rd_we(d_rd_we),
    .d_is_branch(d_is_branch), .d_is_jump(d_is_jump), .d_is_mem(d_is_mem),
    .e_cond(e_cond), .m_mem_ready(m_mem_ready),
    .stall_F(stall_F_t), .stall_D(stall_D_t), .stall_E(stall_E_t), .stall_M(stall_M_t),
    .stall_WB(stall_WB_t), .flush_F(flush_F_t), .flush_D(flush_D_t), .flush_E(flush_E_t),
    .flush_M(flush_M_t), .flush_WB(flush_WB_t), .pc_redirect(pc_redirect_t),
    .mem_timeout(mem_timeout_t), .stall_cnt(stall_cnt_t)
  );

  assign ctl_obs = {stall_F, stall_D, stall_E, stall_M, stall_WB, flush_F,
                    flush_D, flush_E, flush_M, flush_WB, pc_redirect};

  function automatic step_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic used, input logic [4:0] rd, input logic we,
                               input ctl_t ctl);
    step_t s;
    s      = '0;
    s.v    = v;
    s.rs1  = rs1;
    s.rs2  = rs2;
    s.used = used;
    s.rd   = rd;
    s.we   = we;
    s.rdy  = 1'b1;
    s.ctl  = ctl;
    return s;
  endfunction

  function automatic step_t ins(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic we, input ctl_t ctl);
    return mk(1'b1, rs1, rs2, 1'b1, rd, we, ctl);
  endfunction

  function automatic step_t bub(input ctl_t ctl);
    return mk(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, ctl);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input step_t s);
    d_valid     = s.v;
    d_rs1       = s.rs1;
    d_rs2       = s.rs2;
    d_rs1_used  = s.used;
    d_rs2_used  = s.used;
    d_rd        = s.rd;
    d_rd_we     = s.we;
    d_is_branch = s.br;
    d_is_jump   = s.jmp;
    d_is_mem    = s.mem;
    e_cond      = s.cond;
    m_mem_ready = s.rdy;
    sb.push_back(s);
  endtask

  task automatic idle_inputs();
    d_valid = 0; d_rs1 = 0; d_rs2 = 0; d_rs1_used = 0; d_rs2_used = 0; d_rd = 0;
    d_rd_we = 0; d_is_branch = 0; d_is_jump = 0; d_is_mem = 0; e_cond = 0; m_mem_ready = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_inputs();
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 reset = 1'b0;
    #10;
    d_valid = 1; d_rs1 = 5'd5; d_rs1_used = 1; m_mem_ready = 0;
    #1;
    n_cmp++;
    if (ctl_obs !== NONE) begin n_err++; $display("FAIL reset_ctl got %b want %b", ctl_obs, NONE); end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL reset_cnt got %0d want 0", stall_cnt); end
    n_cmp++;
    if (mem_timeout !== 1'b0) begin n_err++; $display("FAIL reset_tmo got %b want 0", mem_timeout); end
    n_cmp++;
    if ({mem_timeout_t, stall_cnt_t} !== 4'b0) begin
      n_err++; $display("FAIL reset_to got %b_%0d want 0_0", mem_timeout_t, stall_cnt_t);
    end
  endtask

  task automatic test_raw();
    step_t q[$];
    step_t e;
    do_reset();
    q.push_back(ins(5'd0, 5'd0, 5'd5, 1'b1, NONE));
    q.push_back(ins(5'd5, 5'd5, 5'd6, 1'b1, RAW));
    q.push_back(ins(5'd5, 5'd5, 5'd6, 1'b1, RAW));
    q.push_back(ins(5'd5, 5'd5, 5'd6, 1'b1, NONE));
    q.push_back(bub(NONE));
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL raw[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
      if (i >= 3) begin
        n_cmp++;
        if (stall_cnt !== 16'd2) begin n_err++; $display("FAIL raw_cnt[%0d] got %0d want 2", i, stall_cnt); end
      end
    end
  endtask

  task automatic test_x0_wb();
    step_t q[$];
    step_t e;
    do_reset();
    q.push_back(ins(5'd0, 5'd0, 5'd0, 1'b1, NONE));
    q.push_back(ins(5'd0, 5'd0, 5'd8, 1'b0, NONE));
    q.push_back(ins(5'd0, 5'd0, 5'd7, 1'b1, NONE));
    q.push_back(mk(1'b0, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0, NONE));
    q.push_back(mk(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0, NONE));
    q.push_back(ins(5'd7, 5'd7, 5'd0, 1'b0, NONE));
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL x0_wb[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL x0_wb_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_branch();
    step_t q[$];
    step_t s, e;
    do_reset();
    s = ins(0, 0, 0, 0, NONE); s.br = 1;   q.push_back(s);
    s = ins(0, 0, 0, 0, NONE); s.cond = 1; q.push_back(s);
    q.push_back(ins(0, 0, 0, 0, RD));
    q.push_back(ins(0, 0, 0, 0, NONE));
    s = ins(0, 0, 0, 0, NONE); s.br = 1;   q.push_back(s);
    q.push_back(ins(0, 0, 0, 0, NONE));
    q.push_back(ins(0, 0, 0, 0, NONE));
    q.push_back(ins(0, 0, 0, 0, NONE));
    s = ins(0, 0, 5'd1, 1, NONE); s.jmp = 1; q.push_back(s);
    q.push_back(ins(0, 0, 0, 0, NONE));
    q.push_back(ins(0, 0, 0, 0, RD));
    q.push_back(ins(0, 0, 0, 0, NONE));
    s = ins(0, 0, 0, 0, NONE); s.br = 1;   q.push_back(s);
    s = ins(0, 0, 0, 0, NONE); s.br = 1; s.cond = 1; q.push_back(s);
    s = ins(0, 0, 0, 0, RD);   s.cond = 1; q.push_back(s);
    q.push_back(ins(0, 0, 0, 0, NONE));
    q.push_back(ins(0, 0, 0, 0, NONE));
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL branch[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
  endtask

  task automatic test_memwait();
    step_t q[$];
    step_t s, e;
    do_reset();
    s = ins(0, 0, 5'd9, 1, NONE); s.mem = 1; q.push_back(s);
    q.push_back(bub(NONE));
    for (int k = 0; k < 5; k++) begin
      s = ins(5'd9, 5'd9, 5'd10, 1, MW); s.rdy = 0; s.tmo4 = (k == 4); q.push_back(s);
    end
    s = ins(5'd9, 5'd9, 5'd10, 1, RAW);  s.tmo4 = 1; q.push_back(s);
    s = ins(5'd9, 5'd9, 5'd10, 1, NONE); s.tmo4 = 1; q.push_back(s);
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL memwait[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd6) begin n_err++; $display("FAIL memwait_cnt got %0d want 6", stall_cnt); end
  endtask

  task automatic test_timeout();
    step_t q[$];
    step_t s, e;
    do_reset();
    s = ins(0, 0, 5'd9, 1, NONE); s.mem = 1; q.push_back(s);
    q.push_back(bub(NONE));
    for (int k = 0; k < 10; k++) begin
      s = bub(MW); s.rdy = 0; s.tmo4 = (k >= 4); q.push_back(s);
    end
    s = bub(NONE); s.tmo4 = 1; q.push_back(s);
    s = bub(NONE); s.tmo4 = 1; q.push_back(s);
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL timeout[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd10) begin n_err++; $display("FAIL timeout_cnt got %0d want 10", stall_cnt); end
    n_cmp++;
    if (stall_cnt_t !== 3'd7) begin n_err++; $display("FAIL cnt_saturate got %0d want 7", stall_cnt_t); end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_cmp++;
    if ({mem_timeout_t, stall_cnt_t} !== 4'b0) begin
      n_err++; $display("FAIL async_clear got %b_%0d want 0_0", mem_timeout_t, stall_cnt_t);
    end
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic test_reset_mid_stall();
    step_t q[$];
    step_t s, e;
    do_reset();
    s = ins(0, 0, 5'd9, 1, NONE); s.mem = 1; q.push_back(s);
    q.push_back(bub(NONE));
    s = bub(MW); s.rdy = 0; q.push_back(s);
    s = bub(MW); s.rdy = 0; q.push_back(s);
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL mid_rst[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
    #1 reset = 1'b0;
    #1;
    n_cmp++;
    if (ctl_obs !== NONE) begin n_err++; $display("FAIL mid_rst_drop got %b want %b", ctl_obs, NONE); end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ctl_obs !== NONE) begin n_err++; $display("FAIL mid_rst_empty got %b want %b", ctl_obs, NONE); end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL mid_rst_cnt got %0d want 0", stall_cnt); end
  endtask

  task automatic test_redir_raw();
    step_t q[$];
    step_t s, e;
    do_reset();
    s = ins(0, 0, 0, 0, NONE); s.br = 1; q.push_back(s);
    s = ins(0, 0, 5'd3, 1, NONE); s.cond = 1; q.push_back(s);
    q.push_back(ins(5'd3, 5'd3, 5'd4, 1, RD));
    q.push_back(ins(5'd3, 5'd3, 5'd0, 0, NONE));
    foreach (q[i]) begin
      tick(); drive(q[i]); @(negedge clk);
      e = sb.pop_front(); n_cmp++;
      if ({ctl_obs, mem_timeout, mem_timeout_t} !== {e.ctl, e.tmo, e.tmo4}) begin
        n_err++; $display("FAIL redir_raw[%0d] got %b_%b_%b want %b_%b_%b", i, ctl_obs, mem_timeout,
                          mem_timeout_t, e.ctl, e.tmo, e.tmo4);
      end
    end
    n_cmp++;
    if (stall_cnt !== 16'd0) begin n_err++; $display("FAIL redir_raw_cnt got %0d want 0", stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_x0_wb();
    test_branch();
    test_memwait();
    test_timeout();
    test_reset_mid_stall();
    test_redir_raw();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage RV32I pipeline (F/D/E/M/WB); drives the per-stage stall_*/flush_* controls and the PC-redirect select.
- Keeps a shadow scoreboard of the in-flight E/M/WB instructions. Uses it to detect RAW hazards (the datapath has no forwarding), resolve taken branches/jumps in M, and freeze the pipe on a data-memory wait handshake.
- Also keeps a memory-wait timeout and a stall-cycle counter.

Parameters:
MEM_TIMEOUT, 64, consecutive M-stage memory wait cycles before mem_timeout is set (1..65535)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
d_valid  in  1  D stage holds a real instruction (not a bubble)
d_rs1  in  5  D source register 1
d_rs1_used  in  1  instruction reads rs1
d_rs2  in  5  D source register 2
d_rs2_used  in  1  instruction reads rs2
d_rd  in  5  D destination register
d_rd_we  in  1  instruction writes rd
d_is_branch  in  1  conditional branch
d_is_jump  in  1  JAL/JALR (unconditional)
d_is_mem  in  1  load or store
e_cond  in  1  branch condition from ALU (result bit 0) for the E-stage instruction
m_mem_ready  in  1  data memory completes the M-stage access this cycle
stall_F, stall_D, stall_E, stall_M, stall_WB  out  1 each  hold the stage register
flush_F, flush_D, flush_E, flush_M, flush_WB  out  1 each  load a bubble into the stage register at the next clk edge
pc_redirect  out  1  select branch target as next PC (drives pc_SEL[0])
mem_timeout  out  1  sticky: an access waited MEM_TIMEOUT cycles
stall_cnt  out  CNT_W  saturating count of cycles with stall_F=1

Behaviour:
- Reset (reset=0, async): all shadow slots invalid, wait_cnt=0, mem_timeout=0, stall_cnt=0. All stall/flush outputs and pc_redirect read 0 while reset is low.
- Shadow slots, updated at posedge clk:
  - E slot: {v, rd, we, br, jmp, mem}.
  - M slot: {v, rd, we, taken, mem}, where taken = E.v & ((E.br & e_cond) | E.jmp), sampled as E advances.
  - WB slot: {v}.
  - The slot contents track the datapath register actions exactly: stall = hold, flush = v<=0, otherwise advance.
- Outputs are combinational from the shadow state and the current inputs.
- Conditions:
  - MEMWAIT = M.v & M.mem & ~m_mem_ready.
  - REDIR = M.v & M.taken (exclusive with MEMWAIT; an instruction is never both mem and branch).
  - RAW = d_valid & (hit(d_rs1, d_rs1_used) | hit(d_rs2, d_rs2_used)).
  - hit(r,u) = u & r!=0 & ((E.v & E.we & E.rd==r) | (M.v & M.we & M.rd==r)).
  - A WB-stage writer is not a hazard: the regfile writes on the falling edge.
- Priority, highest first:
  - MEMWAIT: stall_F, stall_D, stall_E, stall_M = 1; flush_WB = 1. Pipe frozen, WB receives a bubble.
  - REDIR: pc_redirect = 1; flush_D, flush_E, flush_M = 1. The three wrong-path younger instructions are squashed; the branch itself advances to WB. An RAW in the same cycle is ignored.
  - RAW: stall_F, stall_D = 1; flush_E = 1. Decode retries each cycle until the writer reaches WB, so the penalty is at most 2 cycles.
  - Otherwise: all outputs 0.
- flush_F and stall_WB are constant 0.
- Memory wait counter:
  - wait_cnt increments each MEMWAIT cycle and clears on any non-MEMWAIT cycle.
  - When wait_cnt reaches MEM_TIMEOUT-1 while MEMWAIT holds, mem_timeout is set the next cycle. It stays set until reset; the pipe keeps waiting.
- stall_cnt increments on every stall_F=1 cycle and saturates at all-ones.
- Register x0 destinations never cause a hazard.
- Reset mid-stall: outputs drop immediately; the scoreboard empties.

Test Plan:
- RAW: after reset, issue addi x5 (d_rd=5, we) then add x6,x5,x5 next cycle. Required: stall_F=stall_D=flush_E=1 for exactly 2 cycles, then 0; stall_cnt=2.
- x0 and WB writer: writer to x0 followed by a reader of x0 -> no stall. Reader issued 3 cycles after a writer to x7 (writer now in WB) -> no stall.
- Taken branch: d_is_branch=1, e_cond=1 one cycle later. The next cycle must show pc_redirect=1 and flush_D=flush_E=flush_M=1 for exactly 1 cycle. With e_cond=0: no redirect. A JAL redirects regardless of e_cond.
- Memory wait: load reaches M with m_mem_ready=0 for 5 cycles. Required: stall_F/D/E/M=1 and flush_WB=1 for those 5 cycles, released in the cycle m_mem_ready=1; mem_timeout stays 0.
- Timeout: MEM_TIMEOUT=4, m_mem_ready held 0 for 10 cycles -> mem_timeout rises after the 4th wait cycle and stays set after ready; an asynchronous reset low clears it with no clk edge.
- Redirect+RAW: branch in M while D holds a reader of an E-stage writer -> only the redirect response (no stall_F); stall_cnt unchanged.
